register_lock_bank: RTL

REGISTER_LOCK_BANK -- requirements
Module: register_lock_bank

---
 rtl/register_lock_pkg.sv | 20 ++
 rtl/register_lock_cell.sv | 55 +++++
 rtl/register_lock_bank.sv | 113 +++++++++++
 3 files changed

// File: rtl/register_lock_pkg.sv
// Shared constants for the register lock bank.
// Parameter limits, error counter sizing and address helper.
package register_lock_pkg;

  localparam int NUM_REGS_MIN   = 1;
  localparam int NUM_REGS_MAX   = 16;
  localparam int DATA_W_MIN     = 2;
  localparam int DATA_W_MAX     = 32;
  localparam int MAX_WRITES_MIN = 1;
  localparam int MAX_WRITES_MAX = 15;

  localparam int ERR_COUNT_W = 8;
  localparam logic [ERR_COUNT_W-1:0] ERR_COUNT_MAX = 8'd255;

  // Index width for n registers, never below one bit.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/register_lock_cell.sv
// One lockable register: value, write counter and lock flag.
// Accepts writes until locked by request or by write count.
module register_lock_cell
  import register_lock_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int MAX_WRITES = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] value_o,
  output logic              lock_o
);

  localparam int CW = $clog2(MAX_WRITES + 1);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(MAX_WRITES);

  logic [DATA_W-1:0] value_q, value_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              lock_q, lock_d;
  logic              accept;

  assign accept = wr_en_i & ~lock_q;

  // Next state: a locked cell freezes, bit 0 of data is never stored.
  always_comb begin
    value_d = value_q;
    cnt_d   = cnt_q;
    lock_d  = lock_q;
    if (accept) begin
      value_d = {wr_data_i[DATA_W-1:1], 1'b0};
      cnt_d   = cnt_q + CW'(1);
      lock_d  = wr_data_i[0] | (cnt_d == CNT_LIMIT);
    end
  end

  // State registers, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_q <= '0;
      cnt_q   <= '0;
      lock_q  <= 1'b0;
    end else begin
      value_q <= value_d;
      cnt_q   <= cnt_d;
      lock_q  <= lock_d;
    end
  end

  assign value_o = value_q;
  assign lock_o  = lock_q;

endmodule

// File: rtl/register_lock_bank.sv
// Bank of write-limited lockable registers.
// Address decode, registered read port and rejected-write counter.
module register_lock_bank
  import register_lock_pkg::*;
#(
  parameter  int NUM_REGS   = 4,
  parameter  int DATA_W     = 16,
  parameter  int MAX_WRITES = 1,
  localparam int AW         = addr_width(NUM_REGS)
) (
  input  logic                   Clk,
  input  logic                   ip_reset,
  input  logic                   write,
  input  logic [AW-1:0]          wr_addr,
  input  logic [DATA_W-1:0]      Data_in,
  input  logic                   rd_en,
  input  logic [AW-1:0]          rd_addr,
  output logic [DATA_W-1:0]      Data_out,
  output logic                   rd_valid,
  output logic [NUM_REGS-1:0]    lock_status,
  output logic                   wr_err,
  output logic [ERR_COUNT_W-1:0] err_count
);

  logic [NUM_REGS-1:0] wr_sel;
  logic [DATA_W-1:0]   cell_val [NUM_REGS];
  logic                wr_hit;
  logic                tgt_locked;
  logic                reject;
  logic [DATA_W-1:0]   rd_data;

  logic [DATA_W-1:0]      dout_q, dout_d;
  logic                   rvalid_q, rvalid_d;
  logic                   werr_q, werr_d;
  logic [ERR_COUNT_W-1:0] ecnt_q, ecnt_d;

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_cell
      register_lock_cell #(
        .DATA_W    (DATA_W),
        .MAX_WRITES(MAX_WRITES)
      ) u_cell (
        .clk_i    (Clk),
        .rst_i    (ip_reset),
        .wr_en_i  (wr_sel[g]),
        .wr_data_i(Data_in),
        .value_o  (cell_val[g]),
        .lock_o   (lock_status[g])
      );
    end
  endgenerate

  // Write decode: one-hot select and rejection of locked/absent targets.
  always_comb begin
    wr_sel     = '0;
    wr_hit     = 1'b0;
    tgt_locked = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_addr == AW'(i)) begin
        wr_sel[i]  = write;
        wr_hit     = 1'b1;
        tgt_locked = lock_status[i];
      end
    end
    reject = write & (~wr_hit | tgt_locked);
  end

  // Read mux on pre-write state; lock flag shown in bit 0.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == AW'(i)) begin
        rd_data = {cell_val[i][DATA_W-1:1], lock_status[i]};
      end
    end
  end

  // Next state for read response and error reporting.
  always_comb begin
    dout_d   = dout_q;
    rvalid_d = rd_en;
    werr_d   = reject;
    ecnt_d   = ecnt_q;
    if (rd_en) begin
      dout_d = rd_data;
    end
    if (reject && (ecnt_q != ERR_COUNT_MAX)) begin
      ecnt_d = ecnt_q + 1'b1;
    end
  end

  // Output registers; reset discards any pending read or error.
  always_ff @(posedge Clk) begin
    if (ip_reset) begin
      dout_q   <= '0;
      rvalid_q <= 1'b0;
      werr_q   <= 1'b0;
      ecnt_q   <= '0;
    end else begin
      dout_q   <= dout_d;
      rvalid_q <= rvalid_d;
      werr_q   <= werr_d;
      ecnt_q   <= ecnt_d;
    end
  end

  assign Data_out  = dout_q;
  assign rd_valid  = rvalid_q;
  assign wr_err    = werr_q;
  assign err_count = ecnt_q;

endmodule
